// File: rtl/enemy_shot_pool_pkg.sv
// rtl/enemy_shot_pool_pkg.sv - shared sizes, overlap limits and FSM encoding for the enemy shot pool
package enemy_shot_pool_pkg;

  localparam int NSLOT       = 5;
  localparam int COORD_W     = 9;
  localparam int PLAYER_HALF = 10;
  localparam int SHOT_HALF_X = 5;
  localparam int SHOT_HALF_Y = 10;
  localparam int HIT_LIM_X   = PLAYER_HALF + SHOT_HALF_X;
  localparam int HIT_LIM_Y   = PLAYER_HALF + SHOT_HALF_Y;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  // Sum of two slot/enemy indices (each < NSLOT) reduced mod NSLOT.
  function automatic logic [2:0] wrap_slot(input logic [3:0] v);
    return (v >= 4'(NSLOT)) ? 3'(v - 4'(NSLOT)) : v[2:0];
  endfunction

endpackage

// File: rtl/enemy_shot_pool_shot_hit_check.sv
// rtl/enemy_shot_pool_shot_hit_check.sv - combinational shot/player box overlap test
module shot_hit_check
  import enemy_shot_pool_pkg::*;
(
  input  logic [COORD_W-1:0] i_shot_x,
  input  logic [9:0]         i_shot_ny,
  input  logic [9:0]         i_player_x,
  input  logic [9:0]         i_player_y,
  output logic               o_hit
);

  localparam logic signed [10:0] LIM_X = 11'(HIT_LIM_X);
  localparam logic signed [10:0] LIM_Y = 11'(HIT_LIM_Y);

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic signed [10:0] w_adx;
  logic signed [10:0] w_ady;

  // 11-bit signed holds every difference of a 9/10-bit shot and a 10-bit player coordinate.
  assign w_dx  = $signed({2'b00, i_shot_x}) - $signed({1'b0, i_player_x});
  assign w_dy  = $signed({1'b0, i_shot_ny}) - $signed({1'b0, i_player_y});
  assign w_adx = w_dx[10] ? -w_dx : w_dx;
  assign w_ady = w_dy[10] ? -w_dy : w_dy;
  assign o_hit = (w_adx <= LIM_X) && (w_ady <= LIM_Y);

endmodule

// File: rtl/enemy_shot_pool.sv
// rtl/enemy_shot_pool.sv - five enemy projectile slots: per-frame move/retire sweep and round-robin firing
module enemy_shot_pool
  import enemy_shot_pool_pkg::*;
#(
  parameter int SPEED       = 4,
  parameter int FIRE_PERIOD = 30,
  parameter int BOTTOM      = 470,
  parameter int SPAWN_DY    = 10,
  parameter int ENEMY_PITCH = 40
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        i_frame_tick,
  input  logic        i_play,
  input  logic [9:0]  i_enemy_x,
  input  logic [9:0]  i_enemy_y,
  input  logic [4:0]  i_collide,
  input  logic [9:0]  i_player_x,
  input  logic [9:0]  i_player_y,
  output logic [45:0] o_shots_x,
  output logic [44:0] o_shots_y,
  output logic        o_player_hit,
  output logic [3:0]  o_hit_count
);

  localparam int              FC_W    = $clog2(FIRE_PERIOD + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FIRE_PERIOD - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_slot;
  coord_t          r_sx [NSLOT];
  coord_t          r_sy [NSLOT];
  logic [FC_W-1:0] r_fire_cnt;
  logic [2:0]      r_rr_ptr;
  logic            r_player_hit;
  logic [3:0]      r_hit_count;

  logic            w_start;
  logic            w_in_move;
  logic            w_in_fire;
  coord_t          w_cur_x;
  coord_t          w_cur_y;
  logic            w_live;
  logic [9:0]      w_ny;
  logic            w_bottom;
  logic            w_hit_raw;
  logic            w_found;
  logic [2:0]      w_shooter;
  logic            w_free_found;
  logic [2:0]      w_free_idx;
  logic [10:0]     w_sx;
  logic [10:0]     w_sy;
  logic            w_onscreen;
  logic            w_fire_wait;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_frame_tick) w_next_state = ST_MOVE;
      ST_MOVE: if (r_slot == 3'(NSLOT - 1)) w_next_state = ST_FIRE;
      ST_FIRE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (!i_play) w_next_state = ST_IDLE;
  end

  always_comb begin
    w_start   = (r_state == ST_IDLE) && i_frame_tick && i_play;
    w_in_move = (r_state == ST_MOVE);
    w_in_fire = (r_state == ST_FIRE);
  end

  assign w_cur_x  = r_sx[r_slot];
  assign w_cur_y  = r_sy[r_slot];
  assign w_live   = (w_cur_y != '0);
  assign w_ny     = {1'b0, w_cur_y} + 10'(SPEED);
  assign w_bottom = (w_ny >= 10'(BOTTOM));

  shot_hit_check u_hit (
    .i_shot_x   (w_cur_x),
    .i_shot_ny  (w_ny),
    .i_player_x (i_player_x),
    .i_player_y (i_player_y),
    .o_hit      (w_hit_raw)
  );

  // Iterate downward so the alive enemy closest after rr_ptr wins.
  always_comb begin
    w_found   = 1'b0;
    w_shooter = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (!i_collide[wrap_slot(4'(r_rr_ptr) + 4'(k))]) begin
        w_found   = 1'b1;
        w_shooter = wrap_slot(4'(r_rr_ptr) + 4'(k));
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (r_sy[k] == '0) begin
        w_free_found = 1'b1;
        w_free_idx   = 3'(k);
      end
    end
  end

  assign w_sx        = {1'b0, i_enemy_x} + 11'(ENEMY_PITCH) * 11'(w_shooter);
  assign w_sy        = {1'b0, i_enemy_y} + 11'(SPAWN_DY);
  assign w_onscreen  = (w_sx <= 11'd511) && (w_sy >= 11'd1) && (w_sy <= 11'd511);
  assign w_fire_wait = (r_fire_cnt < FC_LAST);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NSLOT; k++) begin
        r_sx[k] <= '0;
        r_sy[k] <= '0;
      end
      r_slot       <= '0;
      r_fire_cnt   <= '0;
      r_rr_ptr     <= '0;
      r_player_hit <= 1'b0;
      r_hit_count  <= '0;
    end else if (!i_play) begin
      for (int k = 0; k < NSLOT; k++) begin
        r_sx[k] <= '0;
        r_sy[k] <= '0;
      end
      r_slot       <= '0;
      r_fire_cnt   <= '0;
      r_player_hit <= 1'b0;
    end else begin
      r_player_hit <= 1'b0;
      if (w_start)
        r_slot <= '0;
      else if (w_in_move)
        r_slot <= (r_slot == 3'(NSLOT - 1)) ? 3'd0 : r_slot + 3'd1;

      if (w_in_move && w_live) begin
        if (w_bottom || w_hit_raw) begin
          r_sx[r_slot] <= '0;
          r_sy[r_slot] <= '0;
        end else begin
          r_sy[r_slot] <= w_ny[COORD_W-1:0];
        end
        if (!w_bottom && w_hit_raw) begin
          r_player_hit <= 1'b1;
          if (r_hit_count != 4'hf) r_hit_count <= r_hit_count + 4'd1;
        end
      end

      // Without a shooter or a free slot the counter stays at its last value and retries next frame.
      if (w_in_fire) begin
        if (w_fire_wait) begin
          r_fire_cnt <= r_fire_cnt + 1'b1;
        end else if (w_found && w_free_found) begin
          if (w_onscreen) begin
            r_sx[w_free_idx] <= w_sx[COORD_W-1:0];
            r_sy[w_free_idx] <= w_sy[COORD_W-1:0];
          end
          r_fire_cnt <= '0;
          r_rr_ptr   <= (w_shooter == 3'(NSLOT - 1)) ? 3'd0 : w_shooter + 3'd1;
        end
      end
    end
  end

  always_comb begin
    o_shots_x = '0;
    o_shots_y = '0;
    for (int k = 0; k < NSLOT; k++) begin
      o_shots_x[k*COORD_W +: COORD_W] = r_sx[k];
      o_shots_y[k*COORD_W +: COORD_W] = r_sy[k];
    end
  end

  assign o_player_hit = r_player_hit;
  assign o_hit_count  = r_hit_count;

endmodule

// File: tb/tb_enemy_shot_pool.sv
// tb/tb_enemy_shot_pool.sv - table-driven, scoreboarded bench for enemy_shot_pool
module tb_enemy_shot_pool;

  logic        dclk = 1'b0;
  logic        clr;
  logic        frame_tick;
  logic        play;
  logic [9:0]  enemy_x, enemy_y, player_x, player_y;
  logic [4:0]  collide;
  logic [45:0] shots_x, f_shots_x;
  logic [44:0] shots_y, f_shots_y;
  logic        player_hit, f_player_hit;
  logic [3:0]  hit_count, f_hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 dclk = ~dclk;

  enemy_shot_pool dut (
    .dclk(dclk), .clr(clr), .i_frame_tick(frame_tick), .i_play(play),
    .i_enemy_x(enemy_x), .i_enemy_y(enemy_y), .i_collide(collide),
    .i_player_x(player_x), .i_player_y(player_y),
    .o_shots_x(shots_x), .o_shots_y(shots_y),
    .o_player_hit(player_hit), .o_hit_count(hit_count)
  );

  // Stationary shots and a 2-tick fire period make a full pool reachable.
  enemy_shot_pool #(.SPEED(0), .FIRE_PERIOD(2)) u_full (
    .dclk(dclk), .clr(clr), .i_frame_tick(frame_tick), .i_play(play),
    .i_enemy_x(enemy_x), .i_enemy_y(enemy_y), .i_collide(collide),
    .i_player_x(player_x), .i_player_y(player_y),
    .o_shots_x(f_shots_x), .o_shots_y(f_shots_y),
    .o_player_hit(f_player_hit), .o_hit_count(f_hit_count)
  );

  typedef struct {
    logic [45:0] sx;
    logic [44:0] sy;
    logic [3:0]  hc;
    int          hits;
  } exp_t;

  typedef struct {
    bit       rst;
    int       ntick;
    bit       dbl;
    bit [4:0] col;
    int       ex, ey, px, py;
    int       slot;
    int       exp_x, exp_y, exp_hc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  int m_x[5], m_y[5];
  int m_fc, m_rr, m_hc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_x[k] = 0;
      m_y[k] = 0;
    end
    m_fc = 0;
    m_rr = 0;
    m_hc = 0;
  endtask

  task automatic model_tick(output int hits);
    int ny, dx, dy, sh, fr, sx, sy;
    hits = 0;
    for (int s = 0; s < 5; s++) begin
      if (m_y[s] != 0) begin
        ny = m_y[s] + 4;
        dx = m_x[s] - int'(player_x);
        dy = ny - int'(player_y);
        if (ny >= 470) begin
          m_y[s] = 0;
        end else if (dx >= -15 && dx <= 15 && dy >= -20 && dy <= 20) begin
          m_y[s] = 0;
          hits++;
          if (m_hc < 15) m_hc++;
        end else begin
          m_y[s] = ny;
        end
      end
    end
    if (m_fc < 29) begin
      m_fc++;
    end else begin
      sh = -1;
      fr = -1;
      for (int k = 0; k < 5; k++)
        if (sh < 0 && !collide[(m_rr + k) % 5]) sh = (m_rr + k) % 5;
      for (int k = 0; k < 5; k++)
        if (fr < 0 && m_y[k] == 0) fr = k;
      if (sh >= 0 && fr >= 0) begin
        sx = int'(enemy_x) + 40 * sh;
        sy = int'(enemy_y) + 10;
        if (sx <= 511 && sy >= 1 && sy <= 511) begin
          m_x[fr] = sx;
          m_y[fr] = sy;
        end
        m_fc = 0;
        m_rr = (sh + 1) % 5;
      end
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.sx = '0;
    e.sy = '0;
    for (int k = 0; k < 5; k++) begin
      if (m_y[k] != 0) begin
        e.sx[k*9 +: 9] = 9'(m_x[k]);
        e.sy[k*9 +: 9] = 9'(m_y[k]);
      end
    end
    e.hc   = 4'(m_hc);
    e.hits = 0;
    return e;
  endfunction

  // x of an empty slot is don't-care; bit 45 must always read 0.
  function automatic logic [45:0] live_mask(input logic [44:0] sy);
    logic [45:0] m;
    m = 46'd0;
    m[45] = 1'b1;
    for (int k = 0; k < 5; k++)
      if (sy[k*9 +: 9] != 9'd0) m[k*9 +: 9] = 9'h1ff;
    return m;
  endfunction

  task automatic run_tick(input bit extra);
    exp_t e;
    int   hits, seen;
    hits = 0;
    if (play) model_tick(hits);
    e = model_snapshot();
    e.hits = hits;
    sb_q.push_back(e);
    @(negedge dclk);
    frame_tick = 1'b1;
    @(negedge dclk);
    frame_tick = extra;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge dclk);
      frame_tick = 1'b0;
      if (player_hit === 1'b1) seen++;
    end
    e = sb_q.pop_front();
    check("sb_shots_y", 64'(shots_y), 64'(e.sy));
    check("sb_shots_x", 64'(shots_x & live_mask(e.sy)), 64'(e.sx));
    check("sb_hit_count", 64'(hit_count), 64'(e.hc));
    check("sb_hit_pulses", 64'(seen), 64'(e.hits));
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge dclk);
    @(negedge dclk);
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    clr = 1'b1; frame_tick = 1'b0; play = 1'b0;
    enemy_x = '0; enemy_y = '0; collide = '0; player_x = '0; player_y = '0;
    model_reset();

    vecs[0]  = '{1'b1, 29, 1'b0, 5'b00000, 100,  50, 600, 900, 0,  -1,   0,  0};
    vecs[1]  = '{1'b0,  1, 1'b0, 5'b00000, 100,  50, 600, 900, 0, 100,  60,  0};
    vecs[2]  = '{1'b0, 29, 1'b1, 5'b00000, 100,  50, 600, 900, 1,  -1,   0,  0};
    vecs[3]  = '{1'b0,  1, 1'b0, 5'b00000, 100,  50, 600, 900, 1, 140,  60,  0};
    vecs[4]  = '{1'b1, 30, 1'b0, 5'b00000, 100, 452, 600, 900, 0, 100, 462,  0};
    vecs[5]  = '{1'b0,  1, 1'b0, 5'b00000, 100, 452, 600, 900, 0, 100, 466,  0};
    vecs[6]  = '{1'b0,  1, 1'b0, 5'b00000, 100, 452, 600, 900, 0,  -1,   0,  0};
    vecs[7]  = '{1'b1, 30, 1'b0, 5'b00000, 200, 290, 210, 310, 0, 200, 300,  0};
    vecs[8]  = '{1'b0,  1, 1'b0, 5'b00000, 200, 290, 210, 310, 0,  -1,   0,  1};
    vecs[9]  = '{1'b0,450, 1'b0, 5'b11110, 200, 290, 210, 310, 0,  -1,   0, 15};
    vecs[10] = '{1'b1, 30, 1'b0, 5'b10111, 100,  50, 600, 900, 0, 220,  60,  0};
    vecs[11] = '{1'b0, 30, 1'b0, 5'b11111, 100,  50, 600, 900, 1,  -1,   0,  0};
    vecs[12] = '{1'b0,  1, 1'b0, 5'b10111, 100,  50, 600, 900, 1, 220,  60,  0};
    vecs[13] = '{1'b1, 30, 1'b0, 5'b00000, 480,  50, 600, 900, 0, 480,  60,  0};
    vecs[14] = '{1'b0, 60, 1'b0, 5'b00000, 480,  50, 600, 900, 1,  -1,   0,  0};
    vecs[15] = '{1'b0, 30, 1'b0, 5'b00000, 300,  50, 600, 900, 1, 420,  60,  0};

    do_reset();
    check("reset_shots_x", 64'(shots_x), 64'd0);
    check("reset_shots_y", 64'(shots_y), 64'd0);
    check("reset_hit", 64'({player_hit, hit_count}), 64'd0);
    play = 1'b1;

    for (int r = 0; r < 16; r++) begin
      if (vecs[r].rst) do_reset();
      collide  = vecs[r].col;
      enemy_x  = 10'(vecs[r].ex);
      enemy_y  = 10'(vecs[r].ey);
      player_x = 10'(vecs[r].px);
      player_y = 10'(vecs[r].py);
      for (int t = 0; t < vecs[r].ntick; t++) run_tick(vecs[r].dbl);
      check($sformatf("row%0d_slot%0d_y", r, vecs[r].slot),
            64'(shots_y[vecs[r].slot*9 +: 9]), 64'(vecs[r].exp_y));
      if (vecs[r].exp_x >= 0)
        check($sformatf("row%0d_slot%0d_x", r, vecs[r].slot),
              64'(shots_x[vecs[r].slot*9 +: 9]), 64'(vecs[r].exp_x));
      check($sformatf("row%0d_hit_count", r), 64'(hit_count), 64'(vecs[r].exp_hc));
    end

    // play low clears the pool next cycle and ignores frame ticks
    @(negedge dclk);
    play = 1'b0;
    @(negedge dclk);
    check("play0_shots_y", 64'(shots_y), 64'd0);
    for (int k = 0; k < 5; k++) m_y[k] = 0;
    m_fc = 0;
    run_tick(1'b0);
    run_tick(1'b0);
    play = 1'b1;
    for (int t = 0; t < 30; t++) run_tick(1'b0);
    check("replay_slot0_x", 64'(shots_x[8:0]), 64'd460);

    // clr in the middle of a sweep
    @(negedge dclk);
    frame_tick = 1'b1;
    @(negedge dclk);
    frame_tick = 1'b0;
    @(negedge dclk);
    clr = 1'b1;
    @(negedge dclk);
    check("clr_mid_shots_x", 64'(shots_x), 64'd0);
    check("clr_mid_shots_y", 64'(shots_y), 64'd0);
    check("clr_mid_hit", 64'({player_hit, hit_count}), 64'd0);
    clr = 1'b0;
    model_reset();
    run_tick(1'b0);

    // full pool: fire counter holds, then fires into the slot a hit frees in the same sweep
    do_reset();
    collide = 5'b00000; enemy_x = 10'd100; enemy_y = 10'd50;
    player_x = 10'd600; player_y = 10'd900;
    for (int t = 0; t < 13; t++) run_tick(1'b0);
    check("full_shots_y", 64'(f_shots_y), 64'({5{9'd60}}));
    check("full_shots_x", 64'(f_shots_x), 64'({1'b0, 9'd260, 9'd220, 9'd180, 9'd140, 9'd100}));
    player_x = 10'd260; player_y = 10'd60;
    run_tick(1'b0);
    check("full_refire_x", 64'(f_shots_x[44:36]), 64'd100);
    check("full_refire_y", 64'(f_shots_y[44:36]), 64'd60);
    check("full_hit_count", 64'(f_hit_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
